// File: rtl/pc_select_ctrl.sv
// PC-source select controller: multicycle FSM that sequences PC+4, branch/jump/jr/rte
// target loads and the exception save / vector-fetch / jump path for the PC register mux.
module pc_select_ctrl #(
  parameter int         MEM_LATENCY = 2,
  parameter logic [7:0] EXC_BASE    = 8'd253
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fetch_req,
  input  logic       decode_valid,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       neg,
  input  logic       exc_req,
  input  logic [1:0] exc_code,
  output logic [2:0] pc_sel,
  output logic       pc_write,
  output logic       epc_write,
  output logic       mem_read,
  output logic [7:0] exc_addr,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_INC, S_DECODE, S_UPDATE, S_EXC_SAVE, S_EXC_WAIT, S_EXC_JUMP, S_DONE
  } state_t;

  localparam logic [2:0] SEL_PC4    = 3'd0;
  localparam logic [2:0] SEL_BRANCH = 3'd1;
  localparam logic [2:0] SEL_JUMP   = 3'd2;
  localparam logic [2:0] SEL_REG    = 3'd3;
  localparam logic [2:0] SEL_VECTOR = 3'd4;
  localparam logic [2:0] SEL_EPC    = 3'd5;

  // Last EXC_WAIT count; unreachable when MEM_LATENCY is 0 since EXC_SAVE skips the wait.
  localparam logic [3:0] LAT_LAST = (MEM_LATENCY == 0) ? 4'd0 : 4'(MEM_LATENCY - 1);

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [1:0] code_q, code_d;
  logic [3:0] cnt_q, cnt_d;

  logic       taken;
  logic [2:0] target;
  logic       exc_allowed;

  // Target resolution from the decoded instruction and ALU compare flags.
  always_comb begin
    taken  = 1'b0;
    target = SEL_PC4;
    case (opcode)
      6'h04: begin taken = zero;          target = SEL_BRANCH; end
      6'h05: begin taken = !zero;         target = SEL_BRANCH; end
      6'h06: begin taken = zero | neg;    target = SEL_BRANCH; end
      6'h07: begin taken = !zero && !neg; target = SEL_BRANCH; end
      6'h02,
      6'h03: begin taken = 1'b1;          target = SEL_JUMP;   end
      6'h00: begin taken = (funct == 6'h08); target = SEL_REG; end
      6'h10: begin taken = 1'b1;          target = SEL_EPC;    end
      default: begin taken = 1'b0;        target = SEL_PC4;    end
    endcase
  end

  assign exc_allowed = (state_q == S_IDLE)   || (state_q == S_INC)  ||
                       (state_q == S_DECODE) || (state_q == S_UPDATE) ||
                       (state_q == S_DONE);

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:     if (fetch_req) state_d = S_INC;
      S_INC:      state_d = S_DECODE;
      S_DECODE: begin
        if (decode_valid) begin
          if (taken) begin
            sel_d   = target;
            state_d = S_UPDATE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_UPDATE:   state_d = S_DONE;
      S_EXC_SAVE: begin
        cnt_d   = 4'd0;
        state_d = (MEM_LATENCY == 0) ? S_EXC_JUMP : S_EXC_WAIT;
      end
      S_EXC_WAIT: begin
        if (cnt_q == LAT_LAST) state_d = S_EXC_JUMP;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      S_EXC_JUMP: state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Exceptions pre-empt any normal transition; code 3 is folded onto invalid-opcode.
    if (exc_req && exc_allowed) begin
      code_d  = (exc_code == 2'd3) ? 2'd0 : exc_code;
      sel_d   = sel_q;
      state_d = S_EXC_SAVE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= SEL_PC4;
      code_q  <= 2'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    pc_sel    = SEL_PC4;
    pc_write  = 1'b0;
    epc_write = 1'b0;
    mem_read  = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_INC:      pc_write = 1'b1;
      S_UPDATE:   begin pc_write = 1'b1; pc_sel = sel_q; end
      S_EXC_SAVE: begin epc_write = 1'b1; mem_read = 1'b1; end
      S_EXC_WAIT: mem_read = 1'b1;
      S_EXC_JUMP: begin pc_write = 1'b1; pc_sel = SEL_VECTOR; end
      S_DONE:     done = 1'b1;
      default:    ;
    endcase
  end

  assign exc_addr = EXC_BASE + {6'd0, code_q};

endmodule
